// File: rtl/psum_drain_seq.sv
// psum_drain_seq: buffers signed partial sums from one systolic-array column
// and streams them to the SFU through a registered output stage, tagged with
// the accumulator row (selLine) and the overwrite/accumulate flag (acc).
module psum_drain_seq #(
    parameter int PSUM_BW  = 16,
    parameter int DEPTH    = 16,
    parameter int SEL_BW   = 4,
    parameter int NUM_ROWS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PSUM_BW-1:0]       in_psum,
    output logic                     in_ready,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [PSUM_BW-1:0]       psum_regA,
    output logic [SEL_BW-1:0]        selLine,
    output logic                     acc,
    output logic                     pass_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SEL_BW-1:0] LAST_ROW = SEL_BW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    state_t state, state_nxt;

    logic [PSUM_BW-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [SEL_BW-1:0]  row;
    logic               first_pass;
    logic               full, empty, push, load, xfer;

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_count = wr_ptr - rd_ptr;

    // in_ready depends only on state/pointers (and reset), never on out_ready.
    assign in_ready  = reset && !full && (state != FLUSH);
    assign out_valid = (state == STREAM);
    assign push      = in_valid && in_ready && !clear;
    assign xfer      = out_valid && out_ready;
    // The output register only takes words already stored in the FIFO, so a
    // push into an empty FIFO costs one extra cycle rather than a comb bypass.
    assign load      = !empty && (!out_valid || out_ready) && !clear;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: clear wins from any state; STREAM exits only once drained.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE:    if (load) state_nxt = STREAM;
                STREAM:  if (xfer && !load) state_nxt = IDLE;
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO pointers; clear empties the queue in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_psum;
    end

    // Output register plus row/pass tracking, advanced on every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psum_regA  <= '0;
            selLine    <= '0;
            acc        <= 1'b0;
            row        <= '0;
            first_pass <= 1'b1;
            pass_done  <= 1'b0;
        end else begin
            pass_done <= xfer && (selLine == LAST_ROW) && !clear;
            if (clear) begin
                row        <= '0;
                first_pass <= 1'b1;
            end else if (load) begin
                psum_regA <= mem[rd_ptr[AW-1:0]];
                selLine   <= row;
                acc       <= !first_pass;
                if (row == LAST_ROW) begin
                    row        <= '0;
                    first_pass <= 1'b0;
                end else begin
                    row <= row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_drain_seq.sv
// Bench for psum_drain_seq: directed scenarios plus a random phase, all
// checked against a transaction-level scoreboard (queue of accepted words,
// row/pass derived from the transfer index since the last clear/reset).
module tb_psum_drain_seq;
    localparam int PSUM_BW  = 16;
    localparam int DEPTH    = 16;
    localparam int SEL_BW   = 4;
    localparam int NUM_ROWS = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [PSUM_BW-1:0]     in_psum;
    logic                   in_ready;
    logic                   clear;
    logic                   out_ready;
    logic                   out_valid;
    logic [PSUM_BW-1:0]     psum_regA;
    logic [SEL_BW-1:0]      selLine;
    logic                   acc;
    logic                   pass_done;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int failures = 0;

    psum_drain_seq #(.PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .SEL_BW(SEL_BW), .NUM_ROWS(NUM_ROWS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_psum(in_psum), .in_ready(in_ready),
        .clear(clear), .out_ready(out_ready), .out_valid(out_valid), .psum_regA(psum_regA),
        .selLine(selLine), .acc(acc), .pass_done(pass_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words accepted but not yet transferred, transfer index
    // since last clear/reset, expected pass_done for the coming cycle.
    logic [PSUM_BW-1:0] q[$];
    int xidx = 0;
    int pd_cnt = 0;
    logic pd_exp = 1'b0;

    // Inputs change 1 time unit after posedge, so values seen at negedge are
    // exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            xidx   = 0;
            pd_exp = 1'b0;
        end else begin
            chk("pass_done", 32'(pass_done), 32'(pd_exp));
            if (pass_done) pd_cnt++;
            pd_exp = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'(0));
                end else begin
                    chk("psum", 32'(psum_regA), 32'(q[0]));
                    chk("sel",  32'(selLine),   32'(xidx % NUM_ROWS));
                    chk("acc",  32'(acc),       32'(xidx >= NUM_ROWS));
                    if (out_ready) begin
                        pd_exp = ((xidx % NUM_ROWS) == NUM_ROWS - 1) && !clear;
                        void'(q.pop_front());
                        xidx++;
                    end
                end
            end
            if (clear) begin
                q.delete();
                xidx   = 0;
                pd_exp = 1'b0;
            end else if (in_valid && in_ready) begin
                q.push_back(in_psum);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PSUM_BW-1:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_psum  = v;
        while (!in_ready && n < 200) begin step(); n++; end
        chk("push_timeout", 32'(n < 200), 32'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((out_valid || fifo_count != 0) && n < 500) begin step(); n++; end
        chk(tag, 32'(n < 500), 32'(1));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk(tag, 32'(n < 100), 32'(1));
    endtask

    initial begin
        int pd0, k, npush, c;
        logic ok;
        reset = 1'b0; in_valid = 1'b0; in_psum = '0; clear = 1'b0; out_ready = 1'b0;

        // 1. reset then idle
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        reset = 1'b1;
        step(); step();
        chk("idle_vld",   32'(out_valid),  32'(0));
        chk("idle_rdy",   32'(in_ready),   32'(1));
        chk("idle_cnt",   32'(fifo_count), 32'(0));
        chk("idle_sel",   32'(selLine),    32'(0));
        chk("idle_acc",   32'(acc),        32'(0));

        // 2. first pass, 5..12, with latency checks
        out_ready = 1'b1;
        pd0 = pd_cnt;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_psum  = 16'(5 + i);
            step();
            if (i == 0) begin
                chk("lat_cnt",  32'(fifo_count), 32'(1));
                chk("lat_vld0", 32'(out_valid),  32'(0));
            end
            if (i == 1) begin
                chk("lat_vld1", 32'(out_valid), 32'(1));
                chk("lat_psum", 32'(psum_regA), 32'(5));
                chk("lat_acc",  32'(acc),       32'(0));
            end
        end
        in_valid = 1'b0;
        wait_drain("drain_p1");
        step(); step();
        chk("pd_p1", 32'(pd_cnt - pd0), 32'(1));

        // 3. second pass, -3..4 (accumulate)
        pd0 = pd_cnt;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_psum  = 16'(-3 + i);
            step();
            if (i == 1) chk("p2_acc", 32'(acc), 32'(1));
        end
        in_valid = 1'b0;
        wait_drain("drain_p2");
        step(); step();
        chk("pd_p2", 32'(pd_cnt - pd0), 32'(1));

        // 4. backpressure: 20 words with out_ready low
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 25; i++) begin
            in_valid = (k < 20);
            in_psum  = 16'(100 + k);
            ok = in_valid && in_ready;
            step();
            if (ok) k++;
        end
        chk("bp_accepted", 32'(k),          32'(17));
        chk("bp_cnt",      32'(fifo_count), 32'(16));
        chk("bp_rdy",      32'(in_ready),   32'(0));
        chk("bp_vld",      32'(out_valid),  32'(1));
        chk("bp_head",     32'(psum_regA),  32'(100));
        chk("bp_sel",      32'(selLine),    32'(0));
        out_ready = 1'b1;
        c = 0;
        while (k < 20 && c < 100) begin
            in_valid = 1'b1;
            in_psum  = 16'(100 + k);
            ok = in_ready;
            step();
            if (ok) k++;
            c++;
        end
        in_valid = 1'b0;
        chk("bp_all_in", 32'(k), 32'(20));
        wait_drain("drain_bp");
        chk("bp_sb_empty", 32'(q.size()), 32'(0));

        // 5. clear mid-pass after the selLine=3 transfer
        npush = ((3 - (xidx % NUM_ROWS)) + NUM_ROWS) % NUM_ROWS + 1;
        for (int i = 0; i < npush; i++) push(16'(40 + i));
        wait_drain("drain_pre_clr");
        chk("pre_clr_sel", 32'(selLine), 32'(3));
        in_valid = 1'b1; in_psum = 16'd99; clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_vld", 32'(out_valid),  32'(0));
        chk("clr_cnt", 32'(fifo_count), 32'(0));
        chk("clr_rdy", 32'(in_ready),   32'(0));
        step();
        chk("clr_rdy_back", 32'(in_ready), 32'(1));
        push(16'd7);
        wait_valid("clr_wait");
        chk("clr_psum", 32'(psum_regA), 32'(7));
        chk("clr_sel",  32'(selLine),   32'(0));
        chk("clr_acc",  32'(acc),       32'(0));
        wait_drain("drain_clr");

        // boundary values pass bit-exact
        push(16'h8000);
        push(16'h7fff);
        push(16'hffff);
        wait_drain("drain_edge");

        // 6. async reset with six words queued
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(16'(200 + i));
        step();
        chk("pre_rst_cnt", 32'(fifo_count), 32'(6));
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("ar_vld",  32'(out_valid),  32'(0));
        chk("ar_cnt",  32'(fifo_count), 32'(0));
        chk("ar_psum", 32'(psum_regA),  32'(0));
        chk("ar_sel",  32'(selLine),    32'(0));
        chk("ar_acc",  32'(acc),        32'(0));
        chk("ar_pd",   32'(pass_done),  32'(0));
        chk("ar_rdy",  32'(in_ready),   32'(0));
        step(); step();
        @(posedge clk); #3;
        reset = 1'b1;
        step();
        out_ready = 1'b1;
        push(16'd55);
        wait_valid("ar_wait");
        chk("ar2_psum", 32'(psum_regA), 32'(55));
        chk("ar2_sel",  32'(selLine),   32'(0));
        chk("ar2_acc",  32'(acc),       32'(0));
        wait_drain("drain_ar");

        // random phase
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 7))
                0:       in_psum = 16'h8000;
                1:       in_psum = 16'h7fff;
                default: in_psum = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        wait_drain("drain_rand");
        step();
        chk("rand_sb_empty", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
